// File: rtl/rx_fifo_pkg.sv
// Shared helpers for the receive FIFO: pointer width and depth legality.
package rx_fifo_pkg;

  // Number of bits needed to index a memory of the given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // A legal depth is a power of two and at least two entries.
  function automatic bit depth_ok(input int depth);
    return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/rx_fifo_ptr.sv
// Wrap-bit pointer register for the receive FIFO: increment enable plus a
// synchronous clear that takes priority over the increment.
module rx_fifo_ptr #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer state: clear wins over increment, rollover is natural.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr_r <= '0;
    end else if (clr) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= ptr_r + W'(1'b1);
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/rx_fifo_sync.sv
// Synchronous receive FIFO with first-word fall-through, occupancy level,
// programmable almost-full/almost-empty flags, flush and sticky overflow.
module rx_fifo_sync
  import rx_fifo_pkg::*;
#(
  parameter  int WIDTH     = 10,
  parameter  int DEPTH     = 4,
  parameter  int AFULL_TH  = DEPTH - 1,
  parameter  int AEMPTY_TH = 1,
  localparam int PW        = ptr_w(DEPTH),
  localparam int LW        = PW + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] DATA_UP,
  input  logic             VALID_UP,
  output logic             READY_UP,
  output logic [WIDTH-1:0] DATA_DOWN,
  output logic             VALID_DOWN,
  input  logic             READY_DOWN,
  output logic [LW-1:0]    LEVEL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic             OVF_STICKY
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("rx_fifo_sync: DEPTH must be a power of two and >= 2");
  end

  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH) ||
      (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_th_chk
    $error("rx_fifo_sync: almost-full/almost-empty threshold out of range");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [LW-1:0]    wr_ptr_s;
  logic [LW-1:0]    rd_ptr_s;
  logic [LW-1:0]    level_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_fire_s;
  logic             rd_fire_s;
  logic             ovf_sticky_r;

  // Full when the index bits match but the wrap bits differ.
  assign full_s    = (wr_ptr_s[PW-1:0] == rd_ptr_s[PW-1:0]) &&
                     (wr_ptr_s[PW] != rd_ptr_s[PW]);
  assign empty_s   = (wr_ptr_s == rd_ptr_s);
  assign level_s   = wr_ptr_s - rd_ptr_s;
  assign wr_fire_s = VALID_UP & ~full_s;
  assign rd_fire_s = READY_DOWN & ~empty_s;

  rx_fifo_ptr #(.W(LW)) u_wr_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (FLUSH),
    .inc   (wr_fire_s),
    .ptr   (wr_ptr_s)
  );

  rx_fifo_ptr #(.W(LW)) u_rd_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (FLUSH),
    .inc   (rd_fire_s),
    .ptr   (rd_ptr_s)
  );

  // Storage: only the addressed entry is written; a flush cycle writes nothing.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_fire_s && !FLUSH) begin
      mem_r[wr_ptr_s[PW-1:0]] <= DATA_UP;
    end
  end

  // Sticky record of any write attempted while the FIFO was full.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf_sticky_r <= 1'b0;
    end else if (FLUSH) begin
      ovf_sticky_r <= 1'b0;
    end else if (VALID_UP && full_s) begin
      ovf_sticky_r <= 1'b1;
    end
  end

  assign READY_UP     = ~full_s;
  assign VALID_DOWN   = ~empty_s;
  assign DATA_DOWN    = mem_r[rd_ptr_s[PW-1:0]];
  assign LEVEL        = level_s;
  assign ALMOST_FULL  = (level_s >= LW'(AFULL_TH));
  assign ALMOST_EMPTY = (level_s <= LW'(AEMPTY_TH));
  assign OVF_STICKY   = ovf_sticky_r;

endmodule

// File: tb/tb_rx_fifo_sync.sv
// Self-checking bench for rx_fifo_sync: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_rx_fifo_sync;

  localparam int WIDTH     = 10;
  localparam int DEPTH     = 4;
  localparam int AFULL_TH  = DEPTH - 1;
  localparam int AEMPTY_TH = 1;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic             CLK;
  logic             RESET;
  logic             FLUSH;
  logic [WIDTH-1:0] DATA_UP;
  logic             VALID_UP;
  logic             READY_UP;
  logic [WIDTH-1:0] DATA_DOWN;
  logic             VALID_DOWN;
  logic             READY_DOWN;
  logic [LW-1:0]    LEVEL;
  logic             ALMOST_FULL;
  logic             ALMOST_EMPTY;
  logic             OVF_STICKY;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: a plain queue of words plus the overflow flag.
  logic [WIDTH-1:0] mq[$];
  bit               ovf_m;
  bit               last_wf;

  rx_fifo_sync #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .DATA_UP(DATA_UP), .VALID_UP(VALID_UP), .READY_UP(READY_UP),
    .DATA_DOWN(DATA_DOWN), .VALID_DOWN(VALID_DOWN), .READY_DOWN(READY_DOWN),
    .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .OVF_STICKY(OVF_STICKY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic drive(input bit vu, input logic [WIDTH-1:0] d, input bit rd, input bit fl);
    VALID_UP   = vu;
    DATA_UP    = d;
    READY_DOWN = rd;
    FLUSH      = fl;
  endtask

  // One clock: model follows the FIFO rules, then settle 1 time unit past the edge.
  task automatic cycle();
    bit wf, rf, fl, ovf_try;
    logic [WIDTH-1:0] d;
    wf      = VALID_UP && (mq.size() < DEPTH);
    rf      = READY_DOWN && (mq.size() > 0);
    ovf_try = VALID_UP && (mq.size() == DEPTH);
    fl      = FLUSH;
    d       = DATA_UP;
    @(posedge CLK);
    if (fl) begin
      mq.delete();
      ovf_m   = 1'b0;
      last_wf = 1'b0;
    end else begin
      if (ovf_try) ovf_m = 1'b1;
      if (rf) void'(mq.pop_front());
      if (wf) mq.push_back(d);
      last_wf = wf;
    end
    #1;
  endtask

  task automatic clean();
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    mq.delete();
    ovf_m = 1'b0;
    #22;
    RESET = 1'b1;
    cycle();
    tests_run++; if (READY_UP !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_up got %b exp 1", READY_UP); end
    tests_run++; if (VALID_DOWN !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_down got %b exp 0", VALID_DOWN); end
    tests_run++; if (LEVEL !== LW'(0)) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", LEVEL); end
    tests_run++; if (ALMOST_EMPTY !== 1'b1) begin tests_failed++; $display("FAIL reset_aempty got %b exp 1", ALMOST_EMPTY); end
    tests_run++; if (ALMOST_FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_afull got %b exp 0", ALMOST_FULL); end
    tests_run++; if (OVF_STICKY !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", OVF_STICKY); end
    tests_run++; if (DATA_DOWN !== '0) begin tests_failed++; $display("FAIL reset_data_down got %h exp 000", DATA_DOWN); end
  endtask

  task automatic test_fill_ovf();
    clean();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
      cycle();
    end
    tests_run++; if (LEVEL !== LW'(4)) begin tests_failed++; $display("FAIL fill_level got %0d exp 4", LEVEL); end
    tests_run++; if (READY_UP !== 1'b0) begin tests_failed++; $display("FAIL fill_ready_up got %b exp 0", READY_UP); end
    tests_run++; if (ALMOST_FULL !== 1'b1) begin tests_failed++; $display("FAIL fill_afull got %b exp 1", ALMOST_FULL); end
    drive(1'b1, 10'h005, 1'b0, 1'b0);
    cycle();
    tests_run++; if (OVF_STICKY !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b exp 1", OVF_STICKY); end
    tests_run++; if (LEVEL !== LW'(4)) begin tests_failed++; $display("FAIL ovf_level got %0d exp 4", LEVEL); end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if (VALID_DOWN !== 1'b1 || DATA_DOWN !== WIDTH'(i)) begin tests_failed++; $display("FAIL drain_order got v=%b d=%h exp v=1 d=%h", VALID_DOWN, DATA_DOWN, WIDTH'(i)); end
      cycle();
    end
    tests_run++; if (VALID_DOWN !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b exp 0", VALID_DOWN); end
    tests_run++; if (OVF_STICKY !== 1'b1) begin tests_failed++; $display("FAIL ovf_hold got %b exp 1", OVF_STICKY); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    int rx;
    rx = 0;
    clean();
    for (int i = 0; i <= 20; i++) begin
      drive(i < 20, WIDTH'(i), 1'b1, 1'b0);
      if (VALID_DOWN) begin
        tests_run++; if (DATA_DOWN !== WIDTH'(rx)) begin tests_failed++; $display("FAIL stream_data got %h exp %h", DATA_DOWN, WIDTH'(rx)); end
        rx++;
      end
      cycle();
      tests_run++; if (LEVEL > LW'(1) || LEVEL !== LW'(mq.size())) begin tests_failed++; $display("FAIL stream_level got %0d exp %0d", LEVEL, mq.size()); end
    end
    tests_run++; if (rx != 20) begin tests_failed++; $display("FAIL stream_count got %0d exp 20", rx); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_full_simul();
    clean();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 10'h0A0 + WIDTH'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 10'h0FF, 1'b1, 1'b0);
    cycle();
    tests_run++; if (LEVEL !== LW'(3)) begin tests_failed++; $display("FAIL fullrw_level got %0d exp 3", LEVEL); end
    tests_run++; if (READY_UP !== 1'b1) begin tests_failed++; $display("FAIL fullrw_ready_up got %b exp 1", READY_UP); end
    tests_run++; if (DATA_DOWN !== 10'h0A1) begin tests_failed++; $display("FAIL fullrw_head got %h exp 0a1", DATA_DOWN); end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tests_run++; if (DATA_DOWN !== 10'h0A0 + WIDTH'(i)) begin tests_failed++; $display("FAIL fullrw_drain got %h exp %h", DATA_DOWN, 10'h0A0 + WIDTH'(i)); end
      cycle();
    end
    tests_run++; if (VALID_DOWN !== 1'b0) begin tests_failed++; $display("FAIL fullrw_empty got %b exp 0", VALID_DOWN); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    clean();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'h030 + WIDTH'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    tests_run++; if (LEVEL !== LW'(3) || OVF_STICKY !== 1'b1) begin tests_failed++; $display("FAIL flush_pre got lvl=%0d ovf=%b exp lvl=3 ovf=1", LEVEL, OVF_STICKY); end
    drive(1'b1, 10'h3AA, 1'b1, 1'b1);
    cycle();
    tests_run++; if (LEVEL !== LW'(0)) begin tests_failed++; $display("FAIL flush_level got %0d exp 0", LEVEL); end
    tests_run++; if (VALID_DOWN !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %b exp 0", VALID_DOWN); end
    tests_run++; if (OVF_STICKY !== 1'b0) begin tests_failed++; $display("FAIL flush_ovf got %b exp 0", OVF_STICKY); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    clean();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 10'h060 + WIDTH'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 10'h077, 1'b0, 1'b0);
    #3;
    RESET = 1'b0;
    #1;
    mq.delete();
    ovf_m = 1'b0;
    tests_run++; if (LEVEL !== LW'(0) || VALID_DOWN !== 1'b0 || READY_UP !== 1'b1) begin tests_failed++; $display("FAIL arst_state got lvl=%0d v=%b r=%b exp 0 0 1", LEVEL, VALID_DOWN, READY_UP); end
    tests_run++; if (DATA_DOWN !== '0 || ALMOST_EMPTY !== 1'b1) begin tests_failed++; $display("FAIL arst_data got d=%h ae=%b exp 000 1", DATA_DOWN, ALMOST_EMPTY); end
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    RESET = 1'b1;
    cycle();
    drive(1'b1, 10'h155, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0);
    tests_run++; if (VALID_DOWN !== 1'b1 || DATA_DOWN !== 10'h155 || LEVEL !== LW'(1)) begin tests_failed++; $display("FAIL arst_first got v=%b d=%h l=%0d exp 1 155 1", VALID_DOWN, DATA_DOWN, LEVEL); end
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit vu, rd, fl;
    logic [WIDTH-1:0] d;
    vu = 1'b0;
    d  = '0;
    clean();
    for (int c = 0; c < 400; c++) begin
      if (!vu) begin
        vu = ($urandom_range(0, 99) < 60);
        d  = WIDTH'($urandom);
      end
      rd = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 49) == 0);
      drive(vu, d, rd, fl);
      cycle();
      if (last_wf || fl) vu = 1'b0;
      tests_run++;
      if (LEVEL !== LW'(mq.size()) || READY_UP !== (mq.size() < DEPTH) ||
          VALID_DOWN !== (mq.size() > 0) || ALMOST_FULL !== (mq.size() >= AFULL_TH) ||
          ALMOST_EMPTY !== (mq.size() <= AEMPTY_TH) || OVF_STICKY !== ovf_m) begin
        tests_failed++;
        $display("FAIL rand_status cyc %0d got l=%0d r=%b v=%b af=%b ae=%b o=%b exp l=%0d o=%b",
                 c, LEVEL, READY_UP, VALID_DOWN, ALMOST_FULL, ALMOST_EMPTY, OVF_STICKY, mq.size(), ovf_m);
      end
      if (mq.size() > 0) begin
        tests_run++; if (DATA_DOWN !== mq[0]) begin tests_failed++; $display("FAIL rand_data cyc %0d got %h exp %h", c, DATA_DOWN, mq[0]); end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_ovf();
    test_stream();
    test_full_simul();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
